// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MA-stage initiator.
// Accepts one load/store over a valid/ready request channel, waits LATENCY
// cycles, performs the word read or store on the edge entering RESP, and holds
// the response on a second valid/ready channel until it is taken.
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-lane byte enables on stores;
// when undefined every non-error store writes the full 32-bit word).
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_be,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   localparam int DEPTH = 1 << ADDR_W;
   // Wait-counter preload; LATENCY=0 never visits WAIT so the value is moot.
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_enter_resp;

   // Latched request
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;

   // Response state
   logic        r_rd_sel;   // response carries load data
   logic        r_err;
   logic [31:0] r_rd_q;     // registered memory read port

   logic [31:0] r_mem [0:DEPTH-1];

   // Request seen by the memory on the access edge. With LATENCY=0 the access
   // happens on the acceptance edge itself, so the live inputs are used then.
   logic              w_acc_we;
   logic [31:0]       w_acc_addr;
   logic [31:0]       w_acc_wdata;
   logic [3:0]        w_acc_be;
   logic              w_acc_err;
   logic [ADDR_W-1:0] w_acc_idx;
   logic [3:0]        w_lane_we;
   logic              w_mem_wr;
   logic              w_mem_rd;

   assign w_acc_we    = (r_state == S_IDLE) ? i_req_we    : r_we;
   assign w_acc_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
   assign w_acc_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
   assign w_acc_be    = (r_state == S_IDLE) ? i_req_be    : r_be;

   // Misaligned, or any address bit above the memory window is set.
   assign w_acc_err = (w_acc_addr[1:0] != 2'b00) ||
                      ((w_acc_addr >> (ADDR_W + 2)) != 32'd0);
   assign w_acc_idx = w_acc_addr[ADDR_W+1:2];

   assign w_mem_wr = w_enter_resp && w_acc_we && !w_acc_err;
   assign w_mem_rd = w_enter_resp && !w_acc_we;

`ifdef DMEM_BYTE_WRITE_EN
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi] = w_acc_be[gi];
   end
`else
   // Byte enables are ignored: every non-error store writes the whole word.
   logic w_unused_be;
   assign w_unused_be = ^w_acc_be;
   assign w_lane_we   = 4'hF;
`endif

   // Next-state, counter and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_enter_resp = 1'b0;
      o_req_ready  = 1'b0;
      o_rsp_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_cnt_next = CNT_LOAD;
               if (LATENCY > 0) begin
                  w_state_next = S_WAIT;
               end else begin
                  w_state_next = S_RESP;
                  w_enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_next = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State, counter, request latch and response flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_be     <= 4'd0;
         r_rd_sel <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (r_state == S_IDLE && i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_be    <= i_req_be;
         end
         if (w_enter_resp) begin
            r_rd_sel <= !w_acc_we && !w_acc_err;
            r_err    <= w_acc_err;
         end
      end
   end

   // Memory array: byte-lane writes and registered read, untouched by reset.
   always_ff @(posedge i_clk) begin
      if (w_mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) begin
               r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
         end
      end
      if (w_mem_rd) begin
         r_rd_q <= r_mem[w_acc_idx];
      end
   end

   assign o_rsp_rdata = r_rd_sel ? r_rd_q : 32'd0;
   assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for single transactions
// on a LATENCY=2 instance, plus hand sequences for backpressure, reset in WAIT
// and RESP, and back-to-back traffic on a LATENCY=0 instance.
module tb_dmem_responder;

   localparam int LAT = 2;

`ifdef DMEM_BYTE_WRITE_EN
   localparam logic [31:0] EXP_BE5 = 32'hDE22_BE44;
   localparam logic [31:0] EXP_BE0 = 32'h0102_0304;
`else
   localparam logic [31:0] EXP_BE5 = 32'h1122_3344;
   localparam logic [31:0] EXP_BE0 = 32'hCAFE_F00D;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b1;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic [3:0]  z_req_be = '0;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .i_req_be(req_be),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(z_req_valid), .o_req_ready(z_req_ready),
      .i_req_we(z_req_we), .i_req_addr(z_req_addr),
      .i_req_wdata(z_req_wdata), .i_req_be(z_req_be),
      .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready),
      .o_rsp_rdata(z_rsp_rdata), .o_rsp_err(z_rsp_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One complete transaction with rsp_ready held high. lat counts rising
   // edges from the request being presented to rsp_valid being seen (-1 on
   // timeout). Request inputs are scrambled right after acceptance.
   task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat, output logic [31:0] rdata, output logic err);
      @(negedge clk);
      chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF;
      req_wdata = 32'hFFFF_FFFF; req_be = ~be;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      if (!rsp_valid) lat = -1;
      @(posedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          cyc;

      vq.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0});
      vq.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0, 1'b0});
      vq.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, EXP_BE5, 1'b0});
      vq.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0, 1'b1});
      vq.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1});
      vq.push_back('{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1});
      vq.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, EXP_BE5, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 32'h0, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h0, 32'h0, 1'b0});
      vq.push_back('{1'b0, 32'h0000_0024, 32'h0,         4'h0, EXP_BE0, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0FFC, 32'h7E7E_7E7E, 4'hF, 32'h0, 1'b0});
      vq.push_back('{1'b1, 32'h0000_0000, 32'h0000_AAAA, 4'hF, 32'h0, 1'b0});
      vq.push_back('{1'b1, 32'h0000_1000, 32'hBBBB_BBBB, 4'hF, 32'h0, 1'b1});
      vq.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_AAAA, 1'b0});
      vq.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h7E7E_7E7E, 1'b0});
      vq.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h0, 1'b1});

      // Reset state
      #2;
      chk("rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);
      chk("rst rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst0 rsp_valid", {31'd0, z_rsp_valid}, 32'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < vq.size(); i++) begin
         do_req($sformatf("vec%0d", i), vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be,
                lat, rd, er);
         chk($sformatf("vec%0d latency", i), lat, LAT + 1);
         chk($sformatf("vec%0d rdata", i), rd, vq[i].exp_rdata);
         chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vq[i].exp_err});
         $display("[TB] vec%0d we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
                  i, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be, rd, er, lat);
      end

      // Backpressure: rsp_ready low for 5 cycles after rsp_valid rises
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      chk("bp rsp_valid rise", {31'd0, rsp_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("bp%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp%0d rdata", k), rsp_rdata, EXP_BE5);
         chk($sformatf("bp%0d err", k), {31'd0, rsp_err}, 32'd0);
         chk($sformatf("bp%0d req_ready", k), {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp release req_ready", {31'd0, req_ready}, 32'd1);
      $display("[TB] backpressure load 0x10 held 5 cycles rdata=%h", EXP_BE5);

      // Reset one cycle after accepting a store to 0x20: store must not land
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555; req_be = 4'hF;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstwait req_ready", {31'd0, req_ready}, 32'd1);
      chk("rstwait rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstwait rdata", rsp_rdata, 32'd0);
      chk("rstwait err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) @(posedge clk);
      @(negedge clk);
      chk("rstwait no late rsp", {31'd0, rsp_valid}, 32'd0);
      do_req("rstwait reload", 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
      chk("rstwait reload rdata", rd, 32'hA5A5_0F0F);
      $display("[TB] reset in WAIT, store 0x20 dropped, reload rdata=%h", rd);

      // Reset while the store response is held in RESP: write persists
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h28; req_wdata = 32'h1234_5678; req_be = 4'hF;
      req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin
         @(posedge clk); @(negedge clk); cyc++;
      end
      chk("rstresp rsp_valid rise", {31'd0, rsp_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstresp rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstresp req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rsp_ready = 1'b1;
      do_req("rstresp reload", 1'b0, 32'h28, 32'h0, 4'h0, lat, rd, er);
      chk("rstresp reload rdata", rd, 32'h1234_5678);
      $display("[TB] reset in RESP, store 0x28 kept, reload rdata=%h", rd);

      // LATENCY=0: store then back-to-back loads with valid held high
      @(negedge clk);
      z_req_we = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h0BAD_F00D; z_req_be = 4'hF;
      z_req_valid = 1'b1; z_rsp_ready = 1'b1;
      chk("lat0 store req_ready", {31'd0, z_req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("lat0 store rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
      chk("lat0 store rdata", z_rsp_rdata, 32'd0);
      z_req_we = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("lat0 c%0d req_ready", k), {31'd0, z_req_ready},
             (k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("lat0 c%0d rsp_valid", k), {31'd0, z_rsp_valid},
             (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k % 2 == 1) begin
            chk($sformatf("lat0 c%0d rdata", k), z_rsp_rdata, 32'h0BAD_F00D);
            $display("[TB] lat0 load 0x40 rdata=%h", z_rsp_rdata);
         end
      end
      z_req_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
